cache_victim_sel: RTL and testbench
===================================

# cache_victim_sel

Parametrised victim-way selector for set-associative caches. Replaces the fixed 8-bit refill LFSR with a configurable XNOR LFSR (8/16/24/32 bits) and adds runtime round-robin mode, invalid-way preference, per-way lock mask, seed reload and a registered req/valid handshake. Sits between the cache miss handler and the tag/data array write-enable logic.

## Interface
- NUM_WAYS, 8: number of ways; power of two, 2..16.
- LFSR_WIDTH, 8: LFSR width; legal values 8, 16, 24, 32.
- SEED, '0: reset value of LFSR, LFSR_WIDTH bits; all-ones is illegal (fatal at elaboration).
- FREE_RUN, 0: 1 = LFSR advances every cycle; 0 = advances only on accepted requests.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_i  in  1  victim request; one request accepted per cycle it is high.
- mode_i  in  1  0 = pseudo-random, 1 = round-robin; sampled with req_i.
- valid_ways_i  in  NUM_WAYS  valid bits of the addressed set.
- lock_ways_i  in  NUM_WAYS  ways excluded from replacement.
- seed_load_i  in  1  load seed_i into LFSR.
- seed_i  in  LFSR_WIDTH  reload value.
- valid_o  out  1  one-cycle pulse, response to req_i of previous cycle.
- victim_oh_o  out  NUM_WAYS  one-hot victim way.
- victim_bin_o  out  $clog2(NUM_WAYS)  binary victim way.
- no_victim_o  out  1  all ways locked; victim outputs zero.
- lfsr_o  out  LFSR_WIDTH  current LFSR state (debug).

## Operation
- LFSR: Fibonacci, shift left, shift_in = XNOR of taps, next = {q[W-2:0], shift_in}. Taps (1-based bit positions): 8: 8,6,5,4; 16: 16,15,13,4; 24: 24,23,22,17; 32: 32,22,2,1.
- Lock-up: all-ones is the XNOR dead state. seed_load_i with seed_i all-ones loads all-zeros instead.
- Candidate set: unlocked ways = ~lock_ways_i.
- Priority 1: any way invalid and unlocked -> lowest-index such way; mode ignored; round-robin pointer unchanged.
- Priority 2, random mode: start index = lfsr_q[$clog2(NUM_WAYS)-1:0].
- Priority 2, round-robin mode: start index = rr_q.
- From the start index, scan upward with wrap-around to the first unlocked way.
- rr_q <= (victim + 1) mod NUM_WAYS only on a round-robin priority-2 grant.
- All ways locked: no_victim_o=1, victim_oh_o=0, victim_bin_o=0; LFSR still advances; rr_q unchanged.
- The selection uses lfsr_q from the request cycle. The LFSR advances on the same edge (req_i high, or every cycle if FREE_RUN=1).
- seed_load_i and advance in the same cycle: load wins. The request in that cycle still uses the old lfsr_q.

## Timing
- Reset values: valid_o=0, victim_oh_o=0, victim_bin_o=0, no_victim_o=0, lfsr_o=SEED, rr_q=0.
- Latency: 1 cycle. req_i high in cycle N gives valid_o=1 in cycle N+1 with victim outputs registered from cycle-N inputs.
- Back-to-back: req_i high for K consecutive cycles gives valid_o high for K consecutive cycles with a fresh victim each cycle.
- Victim/no_victim outputs hold their last value while valid_o=0.
- No backpressure: the consumer must take the response in its valid cycle.
- Reset asserted mid-operation: all outputs return to reset values asynchronously. A pending response is dropped.
- Period: LFSR sequence length is 2^LFSR_WIDTH - 1 states, excluding all-ones.

## Test plan
- Random sequence: NUM_WAYS=4, W=8, SEED=0, all valid, no locks, req_i for 4 cycles -> lfsr_o steps 0x00,0x01,0x03,0x07,0x0F,0x1E; victim_bin_o = 0,1,3,3 on the four valid_o cycles.
- Invalid preference: valid_ways_i=4'b1011, lock=0, random mode -> victim_bin_o=2 regardless of LFSR. valid_ways_i=4'b0110 -> victim_bin_o=0.
- Round-robin with lock: mode_i=1, all valid, lock_ways_i=4'b0100, 5 requests from reset -> victims 0,1,3,0,1.
- All locked: lock_ways_i=4'b1111 -> valid_o=1, no_victim_o=1, victim_oh_o=0. Next unlocked request returns a normal victim with no_victim_o=0.
- Seed load: seed_load_i=1 with seed_i=8'hFF -> lfsr_o=0x00 next cycle. seed_load_i with seed_i=0x5A and req_i in the same cycle -> response uses the old LFSR value, then lfsr_o=0x5A.
- Reset mid-burst: assert rst_ni low while valid_o=1 -> valid_o=0 and lfsr_o=SEED immediately. First request after release uses SEED.

Source files
------------

// File: rtl/cache_victim_sel.sv
// Victim-way selector for a set-associative cache: invalid-way preference, then
// pseudo-random (XNOR LFSR) or round-robin choice among unlocked ways, registered.
module cache_victim_sel #(
  parameter int                    NUM_WAYS   = 8,
  parameter int                    LFSR_WIDTH = 8,
  parameter logic [LFSR_WIDTH-1:0] SEED       = '0,
  parameter bit                    FREE_RUN   = 1'b0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        req_i,
  input  logic                        mode_i,
  input  logic [NUM_WAYS-1:0]         valid_ways_i,
  input  logic [NUM_WAYS-1:0]         lock_ways_i,
  input  logic                        seed_load_i,
  input  logic [LFSR_WIDTH-1:0]       seed_i,
  output logic                        valid_o,
  output logic [NUM_WAYS-1:0]         victim_oh_o,
  output logic [$clog2(NUM_WAYS)-1:0] victim_bin_o,
  output logic                        no_victim_o,
  output logic [LFSR_WIDTH-1:0]       lfsr_o
);

  localparam int IDX_W = $clog2(NUM_WAYS);

  // Tap masks are the 1-based tap positions shifted down to 0-based bits.
  localparam logic [31:0] TAP_MASK32 =
      (LFSR_WIDTH == 8)  ? 32'h0000_00B8 :
      (LFSR_WIDTH == 16) ? 32'h0000_D008 :
      (LFSR_WIDTH == 24) ? 32'h00E1_0000 :
                           32'h8020_0003;
  localparam logic [LFSR_WIDTH-1:0] TAPS = TAP_MASK32[LFSR_WIDTH-1:0];

  if (NUM_WAYS < 2 || NUM_WAYS > 16 || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
    $fatal(1, "cache_victim_sel: NUM_WAYS must be a power of two in 2..16");
  end
  if (LFSR_WIDTH != 8 && LFSR_WIDTH != 16 && LFSR_WIDTH != 24 && LFSR_WIDTH != 32) begin : g_bad_width
    $fatal(1, "cache_victim_sel: LFSR_WIDTH must be 8, 16, 24 or 32");
  end
  if (&SEED) begin : g_bad_seed
    $fatal(1, "cache_victim_sel: SEED must not be all-ones (XNOR lock-up state)");
  end

  logic                  valid_q, valid_d;
  logic [NUM_WAYS-1:0]   victim_oh_q, victim_oh_d;
  logic [IDX_W-1:0]      victim_bin_q, victim_bin_d;
  logic                  no_victim_q, no_victim_d;
  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic [IDX_W-1:0]      rr_q, rr_d;

  logic [NUM_WAYS-1:0]   unlocked;
  logic [NUM_WAYS-1:0]   inv_cand;
  logic                  any_unlocked;
  logic                  inv_found;
  logic [IDX_W-1:0]      inv_idx;
  logic [IDX_W-1:0]      start_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic [IDX_W-1:0]      scan_idx;
  logic [IDX_W-1:0]      victim_idx;
  logic                  shift_in;

  always_comb begin
    unlocked     = ~lock_ways_i;
    inv_cand     = unlocked & ~valid_ways_i;
    any_unlocked = |unlocked;

    // Descending walk so the lowest matching index is the last one written.
    inv_found = 1'b0;
    inv_idx   = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (inv_cand[i]) begin
        inv_found = 1'b1;
        inv_idx   = IDX_W'(i);
      end
    end

    // Wrap-around scan: index arithmetic wraps naturally at IDX_W bits.
    start_idx = mode_i ? rr_q : lfsr_q[IDX_W-1:0];
    scan_idx  = start_idx;
    cand_idx  = start_idx;
    for (int k = NUM_WAYS - 1; k >= 0; k--) begin
      cand_idx = start_idx + IDX_W'(k);
      if (unlocked[cand_idx]) begin
        scan_idx = cand_idx;
      end
    end

    victim_idx = inv_found ? inv_idx : scan_idx;
  end

  always_comb begin
    valid_d      = req_i;
    victim_oh_d  = victim_oh_q;
    victim_bin_d = victim_bin_q;
    no_victim_d  = no_victim_q;
    rr_d         = rr_q;

    if (req_i) begin
      if (any_unlocked) begin
        victim_bin_d = victim_idx;
        victim_oh_d  = NUM_WAYS'(1) << victim_idx;
        no_victim_d  = 1'b0;
        if (mode_i && !inv_found) begin
          rr_d = victim_idx + IDX_W'(1);
        end
      end else begin
        victim_bin_d = '0;
        victim_oh_d  = '0;
        no_victim_d  = 1'b1;
      end
    end
  end

  always_comb begin
    shift_in = ~^(lfsr_q & TAPS);
    lfsr_d   = lfsr_q;
    if (seed_load_i) begin
      // Never load the all-ones dead state.
      lfsr_d = (&seed_i) ? '0 : seed_i;
    end else if (req_i || FREE_RUN) begin
      lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], shift_in};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      victim_oh_q  <= '0;
      victim_bin_q <= '0;
      no_victim_q  <= 1'b0;
      lfsr_q       <= SEED;
      rr_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      victim_oh_q  <= victim_oh_d;
      victim_bin_q <= victim_bin_d;
      no_victim_q  <= no_victim_d;
      lfsr_q       <= lfsr_d;
      rr_q         <= rr_d;
    end
  end

  assign valid_o      = valid_q;
  assign victim_oh_o  = victim_oh_q;
  assign victim_bin_o = victim_bin_q;
  assign no_victim_o  = no_victim_q;
  assign lfsr_o       = lfsr_q;

endmodule

// File: tb/tb_cache_victim_sel.sv
// Directed bench for cache_victim_sel (4 ways, 8-bit LFSR, SEED=0) checked against
// a behavioural model every cycle plus hand-computed literal expectations.
module tb_cache_victim_sel;

  localparam int         NW   = 4;
  localparam int         W    = 8;
  localparam logic [7:0] SEED = 8'h00;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       req_i;
  logic       mode_i;
  logic [3:0] valid_ways_i;
  logic [3:0] lock_ways_i;
  logic       seed_load_i;
  logic [7:0] seed_i;
  logic       valid_o;
  logic [3:0] victim_oh_o;
  logic [1:0] victim_bin_o;
  logic       no_victim_o;
  logic [7:0] lfsr_o;

  int vectors     = 0;
  int miscompares = 0;

  cache_victim_sel #(
    .NUM_WAYS  (NW),
    .LFSR_WIDTH(W),
    .SEED      (SEED),
    .FREE_RUN  (1'b0)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .mode_i      (mode_i),
    .valid_ways_i(valid_ways_i),
    .lock_ways_i (lock_ways_i),
    .seed_load_i (seed_load_i),
    .seed_i      (seed_i),
    .valid_o     (valid_o),
    .victim_oh_o (victim_oh_o),
    .victim_bin_o(victim_bin_o),
    .no_victim_o (no_victim_o),
    .lfsr_o      (lfsr_o)
  );

  always #5 clk_i = ~clk_i;

  // ---------------- behavioural model ----------------
  logic       m_valid = 1'b0;
  logic [1:0] m_bin   = '0;
  logic [3:0] m_oh    = '0;
  logic       m_nov   = 1'b0;
  logic [7:0] m_lfsr  = SEED;
  int         m_rr    = 0;
  int         m_pick;

  // XNOR Fibonacci step with taps at 1-based positions 8,6,5,4.
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    int ones;
    ones = int'(v[7]) + int'(v[5]) + int'(v[4]) + int'(v[3]);
    return {v[6:0], ((ones % 2) == 0) ? 1'b1 : 1'b0};
  endfunction

  // Returns -1 for no victim, way+16 for an invalid-way grant, else the way.
  function automatic int choose(input logic [3:0] v, input logic [3:0] l, input int start);
    for (int w = 0; w < NW; w++) begin
      if (!v[w] && !l[w]) return w + 16;
    end
    for (int o = 0; o < NW; o++) begin
      if (!l[(start + o) % NW]) return (start + o) % NW;
    end
    return -1;
  endfunction

  assign m_pick = choose(valid_ways_i, lock_ways_i, mode_i ? m_rr : (int'(m_lfsr) % NW));

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_valid <= 1'b0;
      m_bin   <= '0;
      m_oh    <= '0;
      m_nov   <= 1'b0;
      m_lfsr  <= SEED;
      m_rr    <= 0;
    end else begin
      m_valid <= req_i;
      if (req_i) begin
        if (m_pick < 0) begin
          m_nov <= 1'b1;
          m_bin <= '0;
          m_oh  <= '0;
        end else begin
          m_nov <= 1'b0;
          m_bin <= 2'(m_pick % 16);
          m_oh  <= 4'(1 << (m_pick % 16));
          if (mode_i && m_pick < 16) m_rr <= (m_pick + 1) % NW;
        end
      end
      if (seed_load_i) m_lfsr <= (seed_i == 8'hFF) ? 8'h00 : seed_i;
      else if (req_i)  m_lfsr <= lfsr_step(m_lfsr);
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    chk("valid_o",      {31'd0, valid_o},      {31'd0, m_valid});
    chk("victim_bin_o", {30'd0, victim_bin_o}, {30'd0, m_bin});
    chk("victim_oh_o",  {28'd0, victim_oh_o},  {28'd0, m_oh});
    chk("no_victim_o",  {31'd0, no_victim_o},  {31'd0, m_nov});
    chk("lfsr_o",       {24'd0, lfsr_o},       {24'd0, m_lfsr});
    $display("t=%0t req=%b mode=%b valid=%b lock=%b -> vo=%b bin=%0d oh=%b nov=%b lfsr=%h",
             $time, req_i, mode_i, valid_ways_i, lock_ways_i,
             valid_o, victim_bin_o, victim_oh_o, no_victim_o, lfsr_o);
  endtask

  task automatic drive(input logic r, input logic m, input logic [3:0] v, input logic [3:0] l,
                       input logic sl, input logic [7:0] s);
    req_i = r; mode_i = m; valid_ways_i = v; lock_ways_i = l; seed_load_i = sl; seed_i = s;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
    cmp_model();
  endtask

  logic [7:0] t1_lfsr[4] = '{8'h01, 8'h03, 8'h07, 8'h0F};
  logic [1:0] t1_bin[4]  = '{2'd0, 2'd1, 2'd3, 2'd3};
  logic [1:0] t3_bin[5]  = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1};

  typedef struct packed {
    logic       r;
    logic       m;
    logic [3:0] v;
    logic [3:0] l;
    logic       sl;
    logic [7:0] s;
  } vec_t;

  vec_t mix[10] = '{
    '{1'b1, 1'b0, 4'hF, 4'b1001, 1'b0, 8'h00},
    '{1'b1, 1'b1, 4'hF, 4'b0011, 1'b0, 8'h00},
    '{1'b1, 1'b1, 4'b0111, 4'b1000, 1'b0, 8'h00},
    '{1'b1, 1'b1, 4'b0111, 4'b0000, 1'b0, 8'h00},
    '{1'b0, 1'b0, 4'hF, 4'b0000, 1'b1, 8'hC3},
    '{1'b1, 1'b0, 4'hF, 4'b0001, 1'b0, 8'h00},
    '{1'b1, 1'b0, 4'b1110, 4'b0001, 1'b0, 8'h00},
    '{1'b1, 1'b1, 4'hF, 4'b1110, 1'b0, 8'h00},
    '{1'b1, 1'b0, 4'hF, 4'b0110, 1'b1, 8'hFF},
    '{1'b1, 1'b0, 4'hF, 4'b0000, 1'b0, 8'h00}
  };

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    step();
    chk("reset valid_o", {31'd0, valid_o}, 32'd0);
    chk("reset lfsr_o", {24'd0, lfsr_o}, 32'h00);
    chk("reset no_victim_o", {31'd0, no_victim_o}, 32'd0);
    rst_ni = 1'b1;

    // Pseudo-random sequence from SEED=0.
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rand lfsr_o", {24'd0, lfsr_o}, {24'd0, t1_lfsr[i]});
      chk("rand victim_bin_o", {30'd0, victim_bin_o}, {30'd0, t1_bin[i]});
    end
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    chk("idle valid_o", {31'd0, valid_o}, 32'd0);
    chk("idle lfsr hold", {24'd0, lfsr_o}, 32'h0F);
    chk("idle bin hold", {30'd0, victim_bin_o}, 32'd3);
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    chk("rand lfsr 5th", {24'd0, lfsr_o}, 32'h1E);

    // Invalid-way preference.
    drive(1'b1, 1'b0, 4'b1011, 4'h0, 1'b0, 8'h00);
    step();
    chk("inv pref bin", {30'd0, victim_bin_o}, 32'd2);
    chk("inv pref oh", {28'd0, victim_oh_o}, 32'h4);
    drive(1'b1, 1'b0, 4'b0110, 4'h0, 1'b0, 8'h00);
    step();
    chk("inv pref low", {30'd0, victim_bin_o}, 32'd0);

    // Round-robin with way 2 locked, from reset.
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    drive(1'b1, 1'b1, 4'hF, 4'b0100, 1'b0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr victim_bin_o", {30'd0, victim_bin_o}, {30'd0, t3_bin[i]});
    end

    // All ways locked, then a normal request.
    drive(1'b1, 1'b1, 4'hF, 4'hF, 1'b0, 8'h00);
    step();
    chk("locked valid_o", {31'd0, valid_o}, 32'd1);
    chk("locked no_victim_o", {31'd0, no_victim_o}, 32'd1);
    chk("locked victim_oh_o", {28'd0, victim_oh_o}, 32'd0);
    drive(1'b1, 1'b1, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    chk("unlock no_victim_o", {31'd0, no_victim_o}, 32'd0);
    chk("unlock rr bin", {30'd0, victim_bin_o}, 32'd2);

    // Seed loading.
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b1, 8'hFF);
    step();
    chk("seed ones -> zero", {24'd0, lfsr_o}, 32'h00);
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b1, 8'h5A);
    step();
    chk("seed+req old lfsr", {30'd0, victim_bin_o}, 32'd0);
    chk("seed+req lfsr_o", {24'd0, lfsr_o}, 32'h5A);
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    chk("post-seed bin", {30'd0, victim_bin_o}, 32'd2);

    // Mixed lock/valid/mode vectors, model-checked.
    for (int i = 0; i < 10; i++) begin
      drive(mix[i].r, mix[i].m, mix[i].v, mix[i].l, mix[i].sl, mix[i].s);
      step();
    end

    // Reset in the middle of a burst.
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    step();
    chk("burst valid_o", {31'd0, valid_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("async rst valid_o", {31'd0, valid_o}, 32'd0);
    chk("async rst lfsr_o", {24'd0, lfsr_o}, {24'd0, SEED});
    chk("async rst oh", {28'd0, victim_oh_o}, 32'd0);
    cmp_model();
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    rst_ni = 1'b1;
    drive(1'b1, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();
    chk("post-rst bin", {30'd0, victim_bin_o}, 32'd0);
    chk("post-rst lfsr", {24'd0, lfsr_o}, 32'h01);
    drive(1'b0, 1'b0, 4'hF, 4'h0, 1'b0, 8'h00);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
